// File: rtl/dot_product_loader_if.sv
// Bundle of the loader's job, operand, core-load and result streams.
// master: the loader itself. slave: the surrounding sequencer/core side.
interface dot_product_loader_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  job_valid;
    logic                  job_ready;
    logic [3:0]            job_len;
    logic                  op_valid;
    logic                  op_ready;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic [DATA_WIDTH-1:0] dp_data;
    logic [2:0]            dp_addr;
    logic                  dp_we_a;
    logic                  dp_we_b;
    logic                  dp_start;
    logic [3:0]            dp_len;
    logic                  dp_done;
    logic [DATA_WIDTH-1:0] dp_result;
    logic                  res_valid;
    logic                  res_ready;
    logic [DATA_WIDTH-1:0] res_data;
    logic                  res_err;
    logic                  len_err;

    modport master (
        input  job_valid, job_len, op_valid, op_a, op_b, dp_done, dp_result, res_ready,
        output job_ready, op_ready, dp_data, dp_addr, dp_we_a, dp_we_b, dp_start,
               dp_len, res_valid, res_data, res_err, len_err
    );

    modport slave (
        output job_valid, job_len, op_valid, op_a, op_b, dp_done, dp_result, res_ready,
        input  job_ready, op_ready, dp_data, dp_addr, dp_we_a, dp_we_b, dp_start,
               dp_len, res_valid, res_data, res_err, len_err
    );
endinterface

// File: rtl/dot_product_loader.sv
// dot_product_loader: takes a job length, pulls operand pairs, writes them
// into the dot-product core's A/B RAMs, starts the core, waits for done and
// returns the result on a valid/ready stream.
// Optional feature macro: DPL_TIMEOUT_EN adds a dp_done watchdog that
// returns res_err=1 / res_data=0 after TIMEOUT_CYCLES cycles in WAIT.
// All outputs are registers or decodes of the state register.
module dot_product_loader #(
`ifdef DPL_TIMEOUT_EN
    parameter int TIMEOUT_CYCLES  = 255,
`endif
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_VECTOR_SIZE = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    dot_product_loader_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WR_A  = 3'd2,
        ST_WR_B  = 3'd3,
        ST_START = 3'd4,
        ST_WAIT  = 3'd5,
        ST_RESP  = 3'd6
    } state_t;

    localparam logic [3:0] MAX_LEN = 4'(MAX_VECTOR_SIZE);

    state_t                state_r;
    state_t                state_nxt_s;
    logic [3:0]            len_r;
    logic [2:0]            idx_r;
    logic [DATA_WIDTH-1:0] a_r;
    logic [DATA_WIDTH-1:0] b_r;
    logic [DATA_WIDTH-1:0] res_data_r;
    logic                  len_err_r;
    logic                  clamp_s;
    logic [3:0]            len_in_s;
    logic [3:0]            idx_inc_s;
    logic                  more_s;
    logic                  timeout_s;

    // Length clamping and "more elements to load" decode.
    always_comb begin
        clamp_s   = (bus.job_len > MAX_LEN);
        len_in_s  = clamp_s ? MAX_LEN : bus.job_len;
        idx_inc_s = {1'b0, idx_r} + 4'd1;
        more_s    = (idx_inc_s < len_r);
    end

`ifdef DPL_TIMEOUT_EN
    // Counter indexes WAIT cycles 0..TIMEOUT_CYCLES-1; the last one times out.
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt_r;
    logic             res_err_r;

    // Watchdog counter: cleared while starting the core, counts while waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_r <= '0;
        end else if (state_r == ST_START) begin
            tmo_cnt_r <= '0;
        end else if (state_r == ST_WAIT) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
        end
    end

    assign timeout_s = (state_r == ST_WAIT) && (tmo_cnt_r == TMO_LAST);
`else
    assign timeout_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; a zero-length job bypasses the core entirely.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.job_valid) begin
                    if (len_in_s == 4'd0) begin
                        state_nxt_s = ST_RESP;
                    end else begin
                        state_nxt_s = ST_FETCH;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (bus.op_valid) begin
                    state_nxt_s = ST_WR_A;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_WR_A:  state_nxt_s = ST_WR_B;
            ST_WR_B: begin
                if (more_s) begin
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_START;
                end
            end
            ST_START: state_nxt_s = ST_WAIT;
            ST_WAIT: begin
                if (bus.dp_done || timeout_s) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (bus.res_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Datapath: job length, element index, operand latches and result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_r      <= 4'd0;
            idx_r      <= 3'd0;
            a_r        <= '0;
            b_r        <= '0;
            res_data_r <= '0;
            len_err_r  <= 1'b0;
`ifdef DPL_TIMEOUT_EN
            res_err_r  <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.job_valid) begin
                        len_r      <= len_in_s;
                        idx_r      <= 3'd0;
                        len_err_r  <= len_err_r | clamp_s;
                        res_data_r <= '0;
`ifdef DPL_TIMEOUT_EN
                        res_err_r  <= 1'b0;
`endif
                    end
                end
                ST_FETCH: begin
                    if (bus.op_valid) begin
                        a_r <= bus.op_a;
                        b_r <= bus.op_b;
                    end
                end
                ST_WR_B: begin
                    idx_r <= idx_inc_s[2:0];
                end
                ST_WAIT: begin
                    // dp_done takes priority over a coincident timeout.
                    if (bus.dp_done) begin
                        res_data_r <= bus.dp_result;
`ifdef DPL_TIMEOUT_EN
                        res_err_r  <= 1'b0;
`endif
                    end else if (timeout_s) begin
                        res_data_r <= '0;
`ifdef DPL_TIMEOUT_EN
                        res_err_r  <= 1'b1;
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode from the state register and the datapath registers.
    always_comb begin
        bus.job_ready = 1'b0;
        bus.op_ready  = 1'b0;
        bus.dp_we_a   = 1'b0;
        bus.dp_we_b   = 1'b0;
        bus.dp_start  = 1'b0;
        bus.res_valid = 1'b0;
        bus.dp_data   = '0;
        case (state_r)
            ST_IDLE:  bus.job_ready = 1'b1;
            ST_FETCH: bus.op_ready  = 1'b1;
            ST_WR_A: begin
                bus.dp_we_a = 1'b1;
                bus.dp_data = a_r;
            end
            ST_WR_B: begin
                bus.dp_we_b = 1'b1;
                bus.dp_data = b_r;
            end
            ST_START: bus.dp_start  = 1'b1;
            ST_RESP:  bus.res_valid = 1'b1;
            default: begin
            end
        endcase
        bus.dp_addr  = idx_r;
        bus.dp_len   = len_r;
        bus.res_data = res_data_r;
        bus.len_err  = len_err_r;
`ifdef DPL_TIMEOUT_EN
        bus.res_err  = res_err_r;
`else
        bus.res_err  = 1'b0;
`endif
    end

endmodule
